br_redirect_ctrl: RTL and testbench

Sequences every front-end redirect in the core. Exception/ertn redirects from commit, branch mispredicts from the EX-stage branch resolve unit, and fetch-packet flushes requested by the predictor check are merged and prioritised into one registered redirect toward IF. The redirect is held until fetch accepts it, and pipeline flush pulses are generated. The block also buffers resolved-branch outcomes in a small FIFO and drains them to the branch predictor's update port under a valid/ready handshake.

---
 rtl/br_redirect_ctrl_pkg.sv | 43 ++++
 rtl/br_redirect_ctrl_if.sv | 40 ++++
 rtl/br_upd_fifo.sv | 51 +++++
 rtl/br_redirect_ctrl.sv | 132 +++++++++++++
 tb/tb_br_redirect_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/br_redirect_ctrl_pkg.sv
// Shared types and constants for the front-end redirect controller.
package br_redirect_ctrl_pkg;

    // Default fetch address issued once after reset.
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    // Redirect source encoding; SRC_NONE means no request this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EXC  = 2'd1,
        SRC_BR   = 2'd2,
        SRC_PRE  = 2'd3
    } src_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_IDLE = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    // One resolved-branch outcome for the predictor.
    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } upd_rec_t;

    // Fixed-priority pick: exception beats mispredict beats predictor flush.
    function automatic src_e sel_src(input logic exc, input logic br, input logic pre);
        src_e s;
        s = SRC_NONE;
        if (exc) begin
            s = SRC_EXC;
        end else if (br) begin
            s = SRC_BR;
        end else if (pre) begin
            s = SRC_PRE;
        end
        return s;
    endfunction

endpackage

// File: rtl/br_redirect_ctrl_if.sv
// Redirect request / fetch redirect / predictor update signal bundle.
interface br_redirect_ctrl_if;
    logic        exc_valid;
    logic [31:0] exc_target;
    logic        br_valid;
    logic [31:0] br_target;
    logic        pre_flush;
    logic [31:0] pre_target;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_front;
    logic        flush_back;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_ready;
    logic [15:0] upd_drop_cnt;

    // Pipeline side driving requests and consuming redirects/updates.
    modport master (
        output exc_valid, exc_target, br_valid, br_target, pre_flush, pre_target,
               res_valid, res_pc, res_taken, res_target, fetch_ready, upd_ready,
        input  redirect_valid, redirect_pc, flush_front, flush_back,
               upd_valid, upd_pc, upd_taken, upd_target, upd_drop_cnt
    );

    // Redirect controller side.
    modport slave (
        input  exc_valid, exc_target, br_valid, br_target, pre_flush, pre_target,
               res_valid, res_pc, res_taken, res_target, fetch_ready, upd_ready,
        output redirect_valid, redirect_pc, flush_front, flush_back,
               upd_valid, upd_pc, upd_taken, upd_target, upd_drop_cnt
    );
endinterface

// File: rtl/br_upd_fifo.sv
// Small synchronous FIFO of predictor updates; reports pushes lost to a full queue.
module br_upd_fifo
    import br_redirect_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push,
    input  upd_rec_t push_data,
    input  logic     pop_req,
    output logic     head_valid,
    output upd_rec_t head_data,
    output logic     drop
);
    localparam int AW = $clog2(DEPTH);

    // Extra MSB is the wrap bit distinguishing full from empty.
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;
    upd_rec_t    mem [DEPTH];
    logic        empty, full, pop, push_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop     = pop_req & ~empty;
    // A full queue can still accept when its head leaves in the same cycle.
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    assign head_valid = ~empty;
    assign head_data  = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end
endmodule

// File: rtl/br_redirect_ctrl.sv
// Merges exception, mispredict and predictor-flush redirects into one held
// fetch redirect with flush pulses, and queues resolved branches for the predictor.
module br_redirect_ctrl
    import br_redirect_ctrl_pkg::*;
#(
    parameter int          UPD_DEPTH = 4,
    parameter logic [31:0] RESET_PC  = br_redirect_ctrl_pkg::RESET_PC
) (
    input logic               clk,
    input logic               rstn,
    br_redirect_ctrl_if.slave bus
);
    state_e      state_reg, state_next;
    logic        redirect_valid_reg, redirect_valid_next;
    logic [31:0] redirect_pc_reg, redirect_pc_next;
    logic        flush_front_reg, flush_front_next;
    logic        flush_back_reg, flush_back_next;
    logic [15:0] drop_cnt_reg;

    src_e        src;
    logic [31:0] win_target;
    logic        upd_push, upd_drop;
    upd_rec_t    push_rec, head_rec;

    assign src = sel_src(bus.exc_valid, bus.br_valid, bus.pre_flush);

    // Target of the winning source.
    always_comb begin
        win_target = bus.pre_target;
        case (src)
            SRC_EXC: win_target = bus.exc_target;
            SRC_BR:  win_target = bus.br_target;
            default: win_target = bus.pre_target;
        endcase
    end

    // Next-state and next-output logic of the redirect FSM.
    always_comb begin
        state_next          = state_reg;
        redirect_valid_next = redirect_valid_reg;
        redirect_pc_next    = redirect_pc_reg;
        flush_front_next    = 1'b0;
        flush_back_next     = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                if (bus.fetch_ready) begin
                    redirect_valid_next = 1'b0;
                    state_next          = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (src != SRC_NONE) begin
                    redirect_valid_next = 1'b1;
                    redirect_pc_next    = win_target;
                    flush_front_next    = 1'b1;
                    flush_back_next     = (src == SRC_EXC);
                    state_next          = ST_PEND;
                end
            end
            ST_PEND: begin
                // Mispredicts and predictor flushes here are wrong-path; only
                // an exception may overwrite the pending redirect.
                if (bus.exc_valid) begin
                    redirect_valid_next = 1'b1;
                    redirect_pc_next    = bus.exc_target;
                    flush_front_next    = 1'b1;
                    flush_back_next     = 1'b1;
                end else if (bus.fetch_ready) begin
                    redirect_valid_next = 1'b0;
                    state_next          = ST_IDLE;
                end
            end
            default: begin
                state_next          = ST_BOOT;
                redirect_valid_next = 1'b1;
                redirect_pc_next    = RESET_PC;
            end
        endcase
    end

    // FSM state and registered redirect outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg          <= ST_BOOT;
            redirect_valid_reg <= 1'b1;
            redirect_pc_reg    <= RESET_PC;
            flush_front_reg    <= 1'b0;
            flush_back_reg     <= 1'b0;
        end else begin
            state_reg          <= state_next;
            redirect_valid_reg <= redirect_valid_next;
            redirect_pc_reg    <= redirect_pc_next;
            flush_front_reg    <= flush_front_next;
            flush_back_reg     <= flush_back_next;
        end
    end

    // A branch resolving alongside an exception is being killed; do not train on it.
    assign upd_push = bus.res_valid & ~bus.exc_valid;
    assign push_rec = '{pc: bus.res_pc, taken: bus.res_taken, target: bus.res_target};

    br_upd_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (upd_push),
        .push_data  (push_rec),
        .pop_req    (bus.upd_ready),
        .head_valid (bus.upd_valid),
        .head_data  (head_rec),
        .drop       (upd_drop)
    );

    // Saturating count of updates lost to a full queue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt_reg <= '0;
        end else if (upd_drop && (drop_cnt_reg != 16'hffff)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign bus.redirect_valid = redirect_valid_reg;
    assign bus.redirect_pc    = redirect_pc_reg;
    assign bus.flush_front    = flush_front_reg;
    assign bus.flush_back     = flush_back_reg;
    assign bus.upd_pc         = head_rec.pc;
    assign bus.upd_taken      = head_rec.taken;
    assign bus.upd_target     = head_rec.target;
    assign bus.upd_drop_cnt   = drop_cnt_reg;
endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Self-checking bench: vector table for redirect behaviour, scoreboard queue
// for predictor updates, hand sequences for FIFO and reset corners.
module tb_br_redirect_ctrl;
    import br_redirect_ctrl_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rstn;
    br_redirect_ctrl_if bif();

    br_redirect_ctrl #(.UPD_DEPTH(DEPTH), .RESET_PC(32'h1c000000)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    upd_rec_t    exp_q[$];
    logic [15:0] drop_exp = 16'd0;

    typedef struct {
        logic        exc;
        logic [31:0] exc_t;
        logic        br;
        logic [31:0] br_t;
        logic        pre;
        logic [31:0] pre_t;
        logic        fr;
        logic        e_v;
        logic [31:0] e_pc;
        logic        e_ff;
        logic        e_fb;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bif.exc_valid = 0; bif.exc_target = '0;
        bif.br_valid = 0;  bif.br_target = '0;
        bif.pre_flush = 0; bif.pre_target = '0;
        bif.res_valid = 0; bif.res_pc = '0; bif.res_taken = 0; bif.res_target = '0;
        bif.fetch_ready = 0; bif.upd_ready = 0;
    endtask

    // One clock: scoreboard bookkeeping for the inputs now applied, then
    // sample after the edge and check the update port.
    task automatic cycle();
        upd_rec_t rec;
        if (bif.upd_ready && exp_q.size() > 0) begin
            chk("upd_pc", bif.upd_pc, exp_q[0].pc);
            chk("upd_taken", {31'd0, bif.upd_taken}, {31'd0, exp_q[0].taken});
            chk("upd_target", bif.upd_target, exp_q[0].target);
            $display("pop  pc=%h taken=%0d target=%h", bif.upd_pc, bif.upd_taken, bif.upd_target);
            void'(exp_q.pop_front());
        end
        if (bif.res_valid && !bif.exc_valid) begin
            rec = '{pc: bif.res_pc, taken: bif.res_taken, target: bif.res_target};
            if (exp_q.size() < DEPTH) exp_q.push_back(rec);
            else if (drop_exp != 16'hffff) drop_exp++;
        end
        @(posedge clk);
        #1;
        chk("upd_valid", {31'd0, bif.upd_valid}, {31'd0, exp_q.size() > 0});
        chk("upd_drop_cnt", {16'd0, bif.upd_drop_cnt}, {16'd0, drop_exp});
    endtask

    task automatic chk_redir(input string tag, input logic v, input logic [31:0] pc,
                             input logic ff, input logic fb);
        chk({tag, ".valid"}, {31'd0, bif.redirect_valid}, {31'd0, v});
        if (v) chk({tag, ".pc"}, bif.redirect_pc, pc);
        chk({tag, ".flush_front"}, {31'd0, bif.flush_front}, {31'd0, ff});
        chk({tag, ".flush_back"}, {31'd0, bif.flush_back}, {31'd0, fb});
        $display("%s: valid=%0d pc=%h ff=%0d fb=%0d", tag, bif.redirect_valid,
                 bif.redirect_pc, bif.flush_front, bif.flush_back);
    endtask

    task automatic push_res(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        bif.res_valid = 1; bif.res_pc = pc; bif.res_taken = tk; bif.res_target = tg;
    endtask

    initial begin
        // exc exc_t br br_t pre pre_t fr | valid pc ff fb
        vecs[0]  = '{0, 32'h0, 1, 32'h1c000040, 1, 32'h1c000080, 0, 1, 32'h1c000040, 1, 0};
        vecs[1]  = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h1c000040, 0, 0};
        vecs[2]  = '{0, 32'h0, 1, 32'h1c000100, 0, 32'h0, 0, 1, 32'h1c000040, 0, 0};
        vecs[3]  = '{1, 32'h1c008000, 0, 32'h0, 0, 32'h0, 0, 1, 32'h1c008000, 1, 1};
        vecs[4]  = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0, 0};
        vecs[5]  = '{0, 32'h0, 0, 32'h0, 1, 32'h1c000200, 0, 1, 32'h1c000200, 1, 0};
        vecs[6]  = '{1, 32'h1c009000, 0, 32'h0, 0, 32'h0, 1, 1, 32'h1c009000, 1, 1};
        vecs[7]  = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0, 0};
        vecs[8]  = '{1, 32'h1c00a000, 1, 32'h1c000500, 1, 32'h1c000600, 0, 1, 32'h1c00a000, 1, 1};
        vecs[9]  = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0, 0};
        vecs[10] = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 0};
        vecs[11] = '{0, 32'h0, 1, 32'h1c000300, 0, 32'h0, 1, 1, 32'h1c000300, 1, 0};
        vecs[12] = '{0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0, 0};

        clear_inputs();
        rstn = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1;
        chk_redir("boot0", 1, 32'h1c000000, 0, 0);
        chk("rst upd_valid", {31'd0, bif.upd_valid}, 32'd0);
        chk("rst drop", {16'd0, bif.upd_drop_cnt}, 32'd0);

        // Boot redirect held while fetch stalls.
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk_redir($sformatf("boot%0d", i), 1, 32'h1c000000, 0, 0);
        end
        bif.fetch_ready = 1;
        cycle();
        chk_redir("boot_acc", 0, 32'h0, 0, 0);

        // Redirect vector table.
        for (int i = 0; i < 13; i++) begin
            clear_inputs();
            bif.exc_valid = vecs[i].exc; bif.exc_target = vecs[i].exc_t;
            bif.br_valid  = vecs[i].br;  bif.br_target  = vecs[i].br_t;
            bif.pre_flush = vecs[i].pre; bif.pre_target = vecs[i].pre_t;
            bif.fetch_ready = vecs[i].fr;
            cycle();
            chk_redir($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_pc, vecs[i].e_ff, vecs[i].e_fb);
        end

        // Overfill the update queue with the predictor stalled.
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            push_res(32'h1c001000 + 32'(i * 4), 1'(i), 32'h1c002000 + 32'(i * 16));
            cycle();
        end
        chk("fill drop", {16'd0, bif.upd_drop_cnt}, 32'd1);
        clear_inputs();
        bif.upd_ready = 1;
        for (int i = 0; i < 5; i++) cycle();

        // Branch killed by a simultaneous exception is not queued.
        clear_inputs();
        bif.exc_valid = 1; bif.exc_target = 32'h1c00c000;
        push_res(32'h1c003000, 1, 32'h1c003400);
        cycle();
        chk_redir("kill", 1, 32'h1c00c000, 1, 1);
        clear_inputs();
        bif.fetch_ready = 1;
        cycle();
        chk_redir("kill_acc", 0, 32'h0, 0, 0);

        // Push and pop together while full: nothing dropped.
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            push_res(32'h1c004000 + 32'(i * 4), 1'(i + 1), 32'h1c005000 + 32'(i * 8));
            cycle();
        end
        push_res(32'h1c004100, 1, 32'h1c005100);
        bif.upd_ready = 1;
        cycle();
        chk("full pushpop drop", {16'd0, bif.upd_drop_cnt}, 32'd1);
        clear_inputs();
        bif.upd_ready = 1;
        for (int i = 0; i < 5; i++) cycle();

        // Asynchronous reset while a redirect is pending and updates are queued.
        clear_inputs();
        push_res(32'h1c006000, 0, 32'h1c006100);
        cycle();
        push_res(32'h1c006004, 1, 32'h1c006200);
        bif.br_valid = 1; bif.br_target = 32'h1c000700;
        cycle();
        chk_redir("pre_rst", 1, 32'h1c000700, 1, 0);
        clear_inputs();
        #2;
        rstn = 0;
        #1;
        chk_redir("async_rst", 1, 32'h1c000000, 0, 0);
        chk("async_rst upd_valid", {31'd0, bif.upd_valid}, 32'd0);
        chk("async_rst drop", {16'd0, bif.upd_drop_cnt}, 32'd0);
        exp_q.delete();
        drop_exp = 16'd0;
        @(posedge clk);
        #1;
        rstn = 1;
        cycle();
        chk_redir("reboot", 1, 32'h1c000000, 0, 0);
        bif.fetch_ready = 1;
        cycle();
        chk_redir("reboot_acc", 0, 32'h0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
